// File: rtl/fp_multiplier_param.sv
// rtl/fp_multiplier_param.sv - parametrised IEEE-754 multiplier, iterative shift-add, start/done handshake
module fp_multiplier_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ready,
  input  logic [EXP_W+MAN_W:0] op1,
  input  logic [EXP_W+MAN_W:0] op2,
  input  logic [1:0]           rm,
  output logic [EXP_W+MAN_W:0] res,
  output logic [3:0]           flags,
  output logic                 busy,
  output logic                 done
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int M    = MAN_W + 1;
  localparam int PW   = 2 * M;
  localparam int QW   = PW - 1;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(M + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_UNPACK  = 3'd1;
  localparam logic [2:0] S_SPECIAL = 3'd2;
  localparam logic [2:0] S_MUL     = 3'd3;
  localparam logic [2:0] S_NORM    = 3'd4;
  localparam logic [2:0] S_ROUND   = 3'd5;
  localparam logic [2:0] S_PACK    = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [W-1:0]     QBIT     = W'(1) << (MAN_W - 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic [2:0]           state;
  logic [W-1:0]         a, b;
  logic [1:0]           rm_r;
  logic                 sign;
  logic [M-1:0]         m1, m2;
  logic signed [EW-1:0] exp_tmp;
  logic [PW-1:0]        prod;
  logic [CW-1:0]        cnt;
  logic [M-1:0]         mant_n, mant_r;
  logic                 guard_n, sticky_n, inexact_r, underflow_r;
  logic [EW-1:0]        exp_n, exp_r;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Operand decode, valid from UNPACK onward since a/b are held until the next request
  logic                 sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  logic [EW-1:0]        exp_calc;
  assign sa = a[W-1];
  assign sb = b[W-1];
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];
  assign a_zero = (ea == '0) && (fa == '0);
  assign b_zero = (eb == '0) && (fb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign exp_calc = {2'b00, (ea == '0) ? EXP_W'(1) : ea}
                  + {2'b00, (eb == '0) ? EXP_W'(1) : eb} - EW'(BIAS);

  logic           spec_hit;
  logic [W-1:0]   spec_res;
  logic [3:0]     spec_flags;
  always_comb begin
    spec_hit   = 1'b1;
    spec_flags = 4'b0000;
    spec_res   = {sa ^ sb, {(W-1){1'b0}}};
    if ((a_zero && b_inf) || (a_inf && b_zero)) begin
      spec_res   = {1'b1, EXP_ONES, {MAN_W{1'b0}}} | QBIT;
      spec_flags = 4'b1000;
    end else if (b_nan) begin
      spec_res   = b | QBIT;
      spec_flags = {~fb[MAN_W-1], 3'b000};
    end else if (a_nan) begin
      spec_res   = a | QBIT;
      spec_flags = {~fa[MAN_W-1], 3'b000};
    end else if (a_zero || b_zero) begin
      spec_res   = {sa ^ sb, {(W-1){1'b0}}};
    end else if (a_inf || b_inf) begin
      spec_res   = {sa ^ sb, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      spec_hit   = 1'b0;
    end
  end

  // Normalise in one step: hidden bit lands on q[QW-1], exponent clamped to >= 1
  logic [QW-1:0] q, mask;
  logic          st1, st2, found, collapse, guard_c, sticky_c;
  logic [M-1:0]  mant_c;
  logic [EW-1:0] exp_c;
  int            ex, lz, sh, rsh;
  always_comb begin
    q = prod[QW-1:0]; mask = '0; st1 = 1'b0; st2 = 1'b0; found = 1'b0; collapse = 1'b0;
    ex = exp_tmp; lz = 0; sh = 0; rsh = 0;
    if (prod[PW-1]) begin
      q   = prod[PW-1:1];
      st1 = prod[0];
      ex  = ex + 1;
    end else begin
      for (int i = QW - 1; i >= 0; i--) begin
        if (!found && prod[i]) begin
          found = 1'b1;
          lz    = QW - 1 - i;
        end
      end
      if (ex > 1) begin
        sh = (lz < ex - 1) ? lz : ex - 1;
        q  = prod[QW-1:0] << sh;
        ex = ex - sh;
      end
    end
    if (ex < 1) begin
      rsh = 1 - ex;
      if (rsh > MAN_W + 2) begin
        collapse = 1'b1;
      end else begin
        mask = (QW'(1) << rsh) - QW'(1);
        st2  = |(q & mask);
        q    = q >> rsh;
      end
      ex = 1;
    end
    mant_c   = q[QW-1:MAN_W];
    guard_c  = q[MAN_W-1];
    sticky_c = (|q[MAN_W-2:0]) | st1 | st2;
    if (collapse) begin
      mant_c   = '0;
      guard_c  = 1'b0;
      sticky_c = 1'b1;
    end
    exp_c = EW'(ex);
  end

  logic       round_up, gs;
  logic [M:0] sum;
  always_comb begin
    gs = guard_n | sticky_n;
    case (rm_r)
      2'b00:   round_up = guard_n & (sticky_n | mant_n[0]);
      2'b01:   round_up = 1'b0;
      2'b10:   round_up = ~sign & gs;
      default: round_up = sign & gs;
    endcase
    sum = {1'b0, mant_n} + {{M{1'b0}}, round_up};
  end

  logic         ovf;
  logic [W-1:0] inf_v, max_v, ovf_v, norm_v;
  always_comb begin
    ovf    = (exp_r >= EW'(EMAX));
    inf_v  = {sign, EXP_ONES, {MAN_W{1'b0}}};
    max_v  = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    case (rm_r)
      2'b00:   ovf_v = inf_v;
      2'b01:   ovf_v = max_v;
      2'b10:   ovf_v = sign ? max_v : inf_v;
      default: ovf_v = sign ? inf_v : max_v;
    endcase
    norm_v = {sign, mant_r[MAN_W] ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}, mant_r[MAN_W-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE; res <= '0; flags <= '0;
      a <= '0; b <= '0; rm_r <= '0; sign <= 1'b0; m1 <= '0; m2 <= '0;
      exp_tmp <= '0; prod <= '0; cnt <= '0;
      mant_n <= '0; guard_n <= 1'b0; sticky_n <= 1'b0; exp_n <= '0;
      mant_r <= '0; exp_r <= '0; inexact_r <= 1'b0; underflow_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (ready) begin
          a <= op1; b <= op2; rm_r <= rm;
          state <= S_UNPACK;
        end
        S_UNPACK: begin
          sign    <= sa ^ sb;
          m1      <= {|ea, fa};
          m2      <= {|eb, fb};
          exp_tmp <= exp_calc;
          prod    <= '0;
          cnt     <= '0;
          state   <= spec_hit ? S_SPECIAL : S_MUL;
        end
        S_SPECIAL: begin
          res   <= spec_res;
          flags <= spec_flags;
          state <= S_DONE;
        end
        S_MUL: begin
          prod <= prod + (m2[cnt] ? (PW'(m1) << cnt) : '0);
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(M - 1)) state <= S_NORM;
        end
        S_NORM: begin
          mant_n <= mant_c; guard_n <= guard_c; sticky_n <= sticky_c; exp_n <= exp_c;
          state  <= S_ROUND;
        end
        S_ROUND: begin
          if (sum[M]) begin
            mant_r <= sum[M:1];
            exp_r  <= exp_n + EW'(1);
          end else begin
            mant_r <= sum[M-1:0];
            exp_r  <= exp_n;
          end
          inexact_r   <= gs;
          underflow_r <= gs & ~mant_n[MAN_W];
          state       <= S_PACK;
        end
        S_PACK: begin
          res   <= ovf ? ovf_v : norm_v;
          flags <= {1'b0, ovf, underflow_r & ~ovf, inexact_r | ovf};
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_multiplier_param.sv
// tb/tb_fp_multiplier_param.sv - directed vectors for fp_multiplier_param (binary32)
module tb_fp_multiplier_param;
  logic        clk = 1'b0;
  logic        rst, ready, busy, done;
  logic [31:0] op1, op2, res;
  logic [1:0]  rm;
  logic [3:0]  flags;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          vec     = 0;

  always #5 clk = ~clk;

  fp_multiplier_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .ready(ready), .op1(op1), .op2(op2), .rm(rm),
    .res(res), .flags(flags), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [1:0] r);
    @(negedge clk);
    op1 = a; op2 = b; rm = r; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic wait_done(output logic got, output int lat);
    got = 1'b0;
    lat = 1;
    while (lat < 200) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_vec(input logic [31:0] a, input logic [31:0] b, input logic [1:0] r,
                        input logic [31:0] exp_res, input logic [3:0] exp_flags, input bit spec);
    logic got;
    int   lat;
    vec++;
    start(a, b, r);
    wait_done(got, lat);
    check($sformatf("v%0d_done", vec), {31'd0, got}, 32'd1);
    check($sformatf("v%0d_res", vec), res, exp_res);
    check($sformatf("v%0d_flags", vec), {28'd0, flags}, {28'd0, exp_flags});
    if (spec) check($sformatf("v%0d_lat", vec), lat, 3);
    else      check($sformatf("v%0d_lat_le58", vec), {31'd0, lat <= 58}, 32'd1);
    @(negedge clk);
    check($sformatf("v%0d_pulse", vec), {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic got;
    int   lat, extra;
    rst = 1'b1; ready = 1'b0; op1 = '0; op2 = '0; rm = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_res", res, 32'h0);
    check("rst_flags", {28'd0, flags}, 32'h0);
    check("rst_busy_done", {30'd0, busy, done}, 32'h0);
    rst = 1'b0;

    do_vec(32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 4'b0000, 1'b0);
    do_vec(32'h00400000, 32'h40000000, 2'b00, 32'h00800000, 4'b0000, 1'b0);
    do_vec(32'h00000000, 32'h7F800000, 2'b00, 32'hFFC00000, 4'b1000, 1'b1);
    do_vec(32'h7FA00000, 32'h3F800000, 2'b00, 32'h7FE00000, 4'b1000, 1'b1);
    do_vec(32'h3F800000, 32'h7FC00001, 2'b00, 32'h7FC00001, 4'b0000, 1'b1);
    do_vec(32'h7FC00000, 32'h7F800001, 2'b00, 32'h7FC00001, 4'b1000, 1'b1);
    do_vec(32'h80000000, 32'h3F800000, 2'b00, 32'h80000000, 4'b0000, 1'b1);
    do_vec(32'h7F800000, 32'hBF800000, 2'b00, 32'hFF800000, 4'b0000, 1'b1);
    do_vec(32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000, 4'b0101, 1'b0);
    do_vec(32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F7FFFFF, 4'b0101, 1'b0);
    do_vec(32'h7F7FFFFF, 32'h40000000, 2'b10, 32'h7F800000, 4'b0101, 1'b0);
    do_vec(32'h7F7FFFFF, 32'h40000000, 2'b11, 32'h7F7FFFFF, 4'b0101, 1'b0);
    do_vec(32'hFF7FFFFF, 32'h40000000, 2'b11, 32'hFF800000, 4'b0101, 1'b0);
    do_vec(32'h3F800001, 32'h3FC00000, 2'b00, 32'h3FC00002, 4'b0001, 1'b0);
    do_vec(32'h3F800001, 32'h3FC00000, 2'b01, 32'h3FC00001, 4'b0001, 1'b0);
    do_vec(32'h3F800001, 32'h3FC00000, 2'b10, 32'h3FC00002, 4'b0001, 1'b0);
    do_vec(32'h00000001, 32'h3F000000, 2'b00, 32'h00000000, 4'b0011, 1'b0);
    do_vec(32'h00000001, 32'h3F000000, 2'b10, 32'h00000001, 4'b0011, 1'b0);
    do_vec(32'h80000001, 32'h3F000000, 2'b00, 32'h80000000, 4'b0011, 1'b0);
    do_vec(32'h007FFFFF, 32'h3F800001, 2'b00, 32'h00800000, 4'b0011, 1'b0);
    do_vec(32'h007FFFFF, 32'h3F800001, 2'b01, 32'h007FFFFF, 4'b0011, 1'b0);
    do_vec(32'h00000001, 32'h00800000, 2'b10, 32'h00000001, 4'b0011, 1'b0);
    do_vec(32'h00000001, 32'h00800000, 2'b00, 32'h00000000, 4'b0011, 1'b0);

    // Give res a nonzero value so the async clear is observable
    do_vec(32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 4'b0000, 1'b0);
    start(32'h3F800001, 32'h3FC00000, 2'b00);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_res", res, 32'h0);
    check("arst_flags", {28'd0, flags}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("arst_no_result", extra, 0);
    do_vec(32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 4'b0000, 1'b0);

    start(32'h3F800001, 32'h3FC00000, 2'b00);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    op1 = 32'h40400000; op2 = 32'h40000000; rm = 2'b01; ready = 1'b1;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    wait_done(got, lat);
    check("ign_done", {31'd0, got}, 32'd1);
    check("ign_res", res, 32'h3FC00002);
    check("ign_flags", {28'd0, flags}, 32'h1);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ign_no_second", extra, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
